// File: rtl/onchip_ram_lockin_capture.sv
// ============================================================================
// onchip_ram_lockin_capture
// ----------------------------------------------------------------------------
// On-chip RAM with two write sources:
//   * s1: an Avalon-MM slave for the host. It supports pipelined reads with a
//     fixed latency and byte-enabled writes, and it stalls through waitrequest.
//   * capture: NUM_CH lock-in result streams. A round-robin arbiter moves one
//     channel word per cycle into that channel's circular region of the RAM.
//
// Parameters
//   DATA_W        word width, multiple of 8
//   ADDR_W        word address width, depth = 2**ADDR_W
//   NUM_CH        capture channels, power of 2, 2 <= NUM_CH < 2**ADDR_W
//   READ_LATENCY  1 = RAM output register only, 2 = extra output register
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   avs_*                        s1 Avalon-MM slave (address, chipselect,
//                                read, write, byteenable, writedata,
//                                readdata, readdatavalid, waitrequest)
//   clken, reset_req             freeze inputs; either one stalls the block
//   ch_valid / ch_data / ch_ready  capture streams (one grant per cycle)
//   ch_clear                     zero all write pointers and wrap flags
//   ch_wrap                      sticky per-channel pointer wrapped flag
// ============================================================================
module onchip_ram_lockin_capture #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 10,
    parameter int NUM_CH       = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        avs_address,
    input  logic                     avs_chipselect,
    input  logic                     avs_read,
    input  logic                     avs_write,
    input  logic [DATA_W/8-1:0]      avs_byteenable,
    input  logic [DATA_W-1:0]        avs_writedata,
    output logic [DATA_W-1:0]        avs_readdata,
    output logic                     avs_readdatavalid,
    output logic                     avs_waitrequest,
    input  logic                     clken,
    input  logic                     reset_req,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic                     ch_clear,
    output logic [NUM_CH-1:0]        ch_wrap
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int BE_W  = DATA_W / 8;
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = ADDR_W - CH_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              r_run;           // low until the first edge after reset
    logic [CH_W-1:0]   r_rr;
    logic [PTR_W-1:0]  r_ptr [NUM_CH];
    logic [NUM_CH-1:0] r_wrap;
    logic [DATA_W-1:0] r_ram_q;
    logic              r_vld1;

    logic              w_frz;
    logic              w_s1_rd;
    logic              w_s1_wr;
    logic              w_s1_wr_eff;
    logic              w_any;
    logic [CH_W-1:0]   w_gnt_idx;
    logic              w_cap_wr;
    logic [ADDR_W-1:0] w_cap_addr;
    logic [DATA_W-1:0] w_cap_data;
    logic [DATA_W-1:0] w_q;
    logic              w_vld;

    // The block also stays frozen until the first edge after reset. This makes
    // waitrequest read 1 and ch_ready read 0 while reset is asserted.
    assign w_frz           = ~clken | reset_req | ~r_run;
    assign avs_waitrequest = w_frz;
    assign w_s1_rd         = avs_chipselect & avs_read  & ~w_frz;
    assign w_s1_wr         = avs_chipselect & avs_write & ~w_frz;

    // Round-robin search. The loop walks offsets downward, so the smallest
    // offset from r_rr is assigned last and wins.
    always_comb begin
        logic [CH_W-1:0] v_idx;
        w_any     = 1'b0;
        w_gnt_idx = '0;
        v_idx     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            v_idx = r_rr + CH_W'(i);
            if (ch_valid[v_idx]) begin
                w_any     = 1'b1;
                w_gnt_idx = v_idx;
            end
        end
    end

    assign w_cap_wr   = w_any & ~w_frz & ~ch_clear;
    assign w_cap_addr = {w_gnt_idx, r_ptr[w_gnt_idx]};
    assign w_cap_data = ch_data[int'(w_gnt_idx)*DATA_W +: DATA_W];

    // On an address collision the capture word wins. The s1 write is dropped,
    // but the s1 transfer still completes without a stall.
    assign w_s1_wr_eff = w_s1_wr & ~(w_cap_wr && (w_cap_addr == avs_address));

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_ready[gi] = w_cap_wr & (w_gnt_idx == CH_W'(gi));
            assign ch_wrap[gi]  = r_wrap[gi];
        end
    endgenerate

    // RAM array. Contents are not reset. The read register is sampled before
    // this edge's writes, so a read of the address being written returns the
    // old data.
    always_ff @(posedge clk) begin
        if (w_s1_wr_eff) begin
            for (int b = 0; b < BE_W; b++) begin
                if (avs_byteenable[b]) begin
                    mem[avs_address][b*8 +: 8] <= avs_writedata[b*8 +: 8];
                end
            end
        end
        if (w_cap_wr) begin
            mem[w_cap_addr] <= w_cap_data;
        end
        if (w_s1_rd) begin
            r_ram_q <= mem[avs_address];
        end
    end

    // Channel pointers, wrap flags, round-robin pointer, read-valid stage 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run  <= 1'b0;
            r_rr   <= '0;
            r_wrap <= '0;
            r_vld1 <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_ptr[c] <= '0;
            end
        end else begin
            r_run <= 1'b1;
            if (!w_frz) begin
                r_vld1 <= w_s1_rd;
            end
            if (w_cap_wr) begin
                r_rr <= w_gnt_idx + CH_W'(1);
            end
            if (ch_clear) begin
                r_wrap <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    r_ptr[c] <= '0;
                end
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ch_ready[c]) begin
                        r_ptr[c] <= r_ptr[c] + PTR_W'(1);
                        if (&r_ptr[c]) begin
                            r_wrap[c] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign w_q   = r_ram_q;
            assign w_vld = r_vld1;
        end else begin : g_lat2
            logic [DATA_W-1:0] r_q2;
            logic              r_vld2;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_q2   <= '0;
                    r_vld2 <= 1'b0;
                end else if (!w_frz) begin
                    r_q2   <= r_ram_q;
                    r_vld2 <= r_vld1;
                end
            end
            assign w_q   = r_q2;
            assign w_vld = r_vld2;
        end
    endgenerate

    // A freeze holds a completed read in the pipe. The read emerges once the
    // freeze clears. readdata is forced to zero outside valid cycles.
    assign avs_readdatavalid = w_vld & ~w_frz;
    assign avs_readdata      = avs_readdatavalid ? w_q : '0;

endmodule
